// File: rtl/noc_flit_route_selector_if.sv
// Flit channel bundle between router stages: per-VC one-hot valid/ready, shared flit bus,
// and a per-VC availability hint flowing back upstream alongside ready.
interface noc_flit_if #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 32
);
  logic [CHANNELS-1:0]   valid;
  logic [CHANNELS-1:0]   ready;
  logic [FLIT_WIDTH-1:0] flit;
  logic [CHANNELS-1:0]   vc_available;

  modport initiator (output valid, output flit, input ready, input vc_available);
  modport target    (input valid, input flit, output ready, output vc_available);

  // master/slave are the same views as initiator/target under their generic names
  modport master    (output valid, output flit, input ready, input vc_available);
  modport slave     (input valid, input flit, output ready, output vc_available);
endinterface

// File: rtl/noc_flit_route_selector.sv
// Packet route latch with a 2-entry flit FIFO driving the downstream demux select.
// Optional macro NOC_ROUTE_SELECTOR_ERROR_CHECK_EN drops packets whose head route is not one-hot.
module noc_flit_route_selector #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 32,
  parameter int ENTRIES    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ENTRIES-1:0] i_route,
  noc_flit_if.target         flit_in_if,
  noc_flit_if.initiator      flit_out_if,
  output logic [ENTRIES-1:0] o_select
`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
  ,
  output logic               o_route_error
`endif
);

  // Head and tail markers occupy the two most significant flit bits.
  localparam int HEAD_BIT = FLIT_WIDTH - 1;
  localparam int TAIL_BIT = FLIT_WIDTH - 2;
  localparam int VC_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
  typedef enum logic [1:0] {IDLE, LOCKED, DROP} state_t;
`else
  typedef enum logic [0:0] {IDLE, LOCKED} state_t;
`endif

  state_t state;
  state_t state_next;

  logic [VC_W-1:0]       lock_vc;
  logic [VC_W-1:0]       lock_vc_next;
  logic [ENTRIES-1:0]    lock_route;
  logic [ENTRIES-1:0]    lock_route_next;

  logic [CHANNELS-1:0]   fifo_ch    [2];
  logic [FLIT_WIDTH-1:0] fifo_flit  [2];
  logic [ENTRIES-1:0]    fifo_route [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  in_head;
  logic                  in_tail;
  logic                  in_accept;
  logic                  in_write;
  logic                  out_read;
  logic [VC_W-1:0]       in_vc;
  logic [ENTRIES-1:0]    write_route;

  assign fifo_full  = (count == 2'd2);
  assign fifo_empty = (count == 2'd0);
  assign in_head    = flit_in_if.flit[HEAD_BIT];
  assign in_tail    = flit_in_if.flit[TAIL_BIT];
  assign in_accept  = |(flit_in_if.valid & flit_in_if.ready);
  assign out_read   = !fifo_empty && |(flit_out_if.valid & flit_out_if.ready);

`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
  logic route_bad;
  assign route_bad = in_head && !$onehot(i_route);
  assign in_write  = in_accept && !route_bad && (state != DROP);
`else
  assign in_write  = in_accept;
`endif

  // Body and tail flits inherit the route latched from their packet's head.
  assign write_route = in_head ? i_route : lock_route;

  always_comb begin
    in_vc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (flit_in_if.valid[c]) begin
        in_vc = VC_W'(c);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (in_write) begin
      fifo_ch[wr_ptr]    <= flit_in_if.valid;
      fifo_flit[wr_ptr]  <= flit_in_if.flit;
      fifo_route[wr_ptr] <= write_route;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (in_write) begin
        wr_ptr <= ~wr_ptr;
      end
      if (out_read) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({in_write, out_read})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      lock_vc    <= '0;
      lock_route <= '0;
    end else begin
      state      <= state_next;
      lock_vc    <= lock_vc_next;
      lock_route <= lock_route_next;
    end
  end

  always_comb begin
    state_next      = state;
    lock_vc_next    = lock_vc;
    lock_route_next = lock_route;
    case (state)
      IDLE: begin
        if (in_accept && in_head && !in_tail) begin
          lock_vc_next    = in_vc;
          lock_route_next = i_route;
`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
          state_next      = route_bad ? DROP : LOCKED;
`else
          state_next      = LOCKED;
`endif
        end
      end
      LOCKED: begin
        if (in_accept && in_tail) begin
          state_next = IDLE;
        end
      end
`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
      DROP: begin
        if (in_accept && in_tail) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Ready looks only at registered count and lock so no input-to-output path exists.
  always_comb begin
    flit_in_if.ready = '0;
    if (!fifo_full) begin
      if (state == IDLE) begin
        flit_in_if.ready = '1;
      end else begin
        flit_in_if.ready[lock_vc] = 1'b1;
      end
    end
  end

  assign flit_out_if.valid       = fifo_empty ? '0 : fifo_ch[rd_ptr];
  assign flit_out_if.flit        = fifo_empty ? '0 : fifo_flit[rd_ptr];
  assign o_select                = fifo_empty ? '0 : fifo_route[rd_ptr];
  assign flit_in_if.vc_available = flit_out_if.vc_available;

`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_route_error <= 1'b0;
    end else begin
      o_route_error <= in_accept && route_bad && (state == IDLE);
    end
  end
`endif

  a_valid_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(flit_in_if.valid));

  a_body_needs_lock: assert property (@(posedge i_clk) disable iff (i_rst)
    (in_accept && !in_head) |-> (state != IDLE));

  a_head_needs_idle: assert property (@(posedge i_clk) disable iff (i_rst)
    (in_accept && in_head) |-> (state == IDLE));

endmodule

// File: tb/tb_noc_flit_route_selector.sv
// Bench for noc_flit_route_selector: directed packet scenarios, then random traffic,
// all compared against a queue-based packet model.
module tb_noc_flit_route_selector;

  localparam int CH   = 2;
  localparam int FW   = 16;
  localparam int EN   = 2;
  localparam int PW   = FW - 2;
  localparam int HEAD = FW - 1;
  localparam int TAIL = FW - 2;

  typedef struct packed {
    logic [CH-1:0] ch;
    logic [FW-1:0] flit;
    logic [EN-1:0] route;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [EN-1:0] route;
  logic [EN-1:0] select;
`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
  logic          route_error;
`endif

  noc_flit_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) in_if ();
  noc_flit_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) out_if ();

  always #5 clk = ~clk;

  noc_flit_route_selector #(.CHANNELS(CH), .FLIT_WIDTH(FW), .ENTRIES(EN)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_route     (route),
    .flit_in_if  (in_if),
    .flit_out_if (out_if),
    .o_select    (select)
`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
    ,
    .o_route_error (route_error)
`endif
  );

  entry_t        model_q[$];
  int            lock_vc_m;
  logic [EN-1:0] lock_route_m;
  bit            drop_m;
  bit            err_m;
  bit            last_acc;
  int            rem;
  int            errors;
  int            checks;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] exp_ready();
    if (model_q.size() >= 2) return '0;
    if (lock_vc_m < 0) return '1;
    return CH'(1) << lock_vc_m;
  endfunction

  function automatic logic [FW-1:0] mk_flit(input bit h, input bit t, input logic [PW-1:0] p);
    return {h, t, p};
  endfunction

  task automatic compare_outputs();
    entry_t h;
    h = '0;
    if (model_q.size() != 0) h = model_q[0];
    check_output("out_valid", 64'(out_if.valid), 64'(h.ch));
    check_output("out_flit", 64'(out_if.flit), 64'(h.flit));
    check_output("select", 64'(select), 64'(h.route));
    check_output("in_ready", 64'(in_if.ready), 64'(exp_ready()));
`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
    check_output("route_error", 64'(route_error), 64'(err_m));
`endif
  endtask

  // One clock of stimulus; the model advances by the packet rules, then outputs are compared.
  task automatic apply_stimulus(input logic [CH-1:0] vld, input logic [FW-1:0] fl,
                                input logic [EN-1:0] rt, input logic [CH-1:0] ordy,
                                input logic [CH-1:0] vca);
    logic [CH-1:0] rdy;
    bit            acc, rd, head, tail, bad;
    int            c;
    in_if.valid         = vld;
    in_if.flit          = fl;
    route               = rt;
    out_if.ready        = ordy;
    out_if.vc_available = vca;
    #1;
    check_output("vc_available", 64'(in_if.vc_available), 64'(vca));
    rdy  = exp_ready();
    acc  = (vld & rdy) != '0;
    rd   = (model_q.size() != 0) && ((model_q[0].ch & ordy) != '0);
    head = fl[HEAD];
    tail = fl[TAIL];
    c = 0;
    for (int i = 0; i < CH; i++) if (vld[i]) c = i;
    bad = 1'b0;
`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
    bad = head && ($countones(rt) != 1);
`endif
    @(posedge clk);
    #1;
    err_m = 1'b0;
    if (rd) void'(model_q.pop_front());
    if (acc) begin
      if (head) begin
        if (bad) begin
          err_m = 1'b1;
          if (!tail) begin
            lock_vc_m = c;
            drop_m    = 1'b1;
          end
        end else begin
          model_q.push_back(entry_t'{ch: vld, flit: fl, route: rt});
          if (!tail) begin
            lock_vc_m    = c;
            lock_route_m = rt;
          end
        end
      end else begin
        if (!drop_m) model_q.push_back(entry_t'{ch: vld, flit: fl, route: lock_route_m});
        if (tail) begin
          lock_vc_m = -1;
          drop_m    = 1'b0;
        end
      end
    end
    last_acc = acc;
    compare_outputs();
  endtask

  task automatic send_flit(input int vc, input logic [FW-1:0] fl, input logic [EN-1:0] rt,
                           input logic [CH-1:0] ordy);
    int n;
    n = 0;
    do begin
      apply_stimulus(CH'(1) << vc, fl, rt, ordy, CH'($urandom));
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      checks++;
      errors++;
      $error("[TB] FAIL send_timeout: vc %0d flit not accepted in %0d cycles, required acceptance", vc, n);
    end
  endtask

  task automatic idle(input int n, input logic [CH-1:0] ordy);
    for (int i = 0; i < n; i++) apply_stimulus('0, '0, '0, ordy, CH'($urandom));
  endtask

  task automatic apply_reset();
    rst                 = 1'b1;
    in_if.valid         = '0;
    in_if.flit          = '0;
    route               = '0;
    out_if.ready        = '0;
    out_if.vc_available = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    lock_vc_m    = -1;
    lock_route_m = '0;
    drop_m       = 1'b0;
    err_m        = 1'b0;
    rem          = 0;
    compare_outputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    apply_reset();
    $display("[TB] single-flit packet");
    send_flit(0, mk_flit(1, 1, PW'(14'h0a1)), 2'b10, 2'b11);
    idle(2, 2'b11);

    $display("[TB] 4-flit packet with output stall");
    send_flit(1, mk_flit(1, 0, PW'(14'h101)), 2'b01, 2'b00);
    send_flit(1, mk_flit(0, 0, PW'(14'h102)), 2'b10, 2'b00);
    repeat (3) apply_stimulus(2'b10, mk_flit(0, 0, PW'(14'h103)), 2'b10, 2'b00, 2'b01);
    send_flit(1, mk_flit(0, 0, PW'(14'h103)), 2'b10, 2'b11);
    send_flit(1, mk_flit(0, 1, PW'(14'h104)), 2'b10, 2'b11);
    idle(3, 2'b11);

    $display("[TB] lock blocks other VC");
    send_flit(0, mk_flit(1, 0, PW'(14'h201)), 2'b10, 2'b11);
    repeat (2) apply_stimulus(2'b10, mk_flit(1, 1, PW'(14'h301)), 2'b01, 2'b11, 2'b10);
    send_flit(0, mk_flit(0, 0, PW'(14'h202)), 2'b01, 2'b11);
    send_flit(0, mk_flit(0, 1, PW'(14'h203)), 2'b01, 2'b11);
    send_flit(1, mk_flit(1, 1, PW'(14'h301)), 2'b01, 2'b11);
    idle(2, 2'b11);

    $display("[TB] back-to-back packets");
    send_flit(0, mk_flit(1, 0, PW'(14'h401)), 2'b01, 2'b11);
    send_flit(0, mk_flit(0, 1, PW'(14'h402)), 2'b10, 2'b11);
    send_flit(1, mk_flit(1, 0, PW'(14'h501)), 2'b10, 2'b11);
    send_flit(1, mk_flit(0, 1, PW'(14'h502)), 2'b01, 2'b11);
    idle(3, 2'b11);

    $display("[TB] reset mid-packet");
    send_flit(0, mk_flit(1, 0, PW'(14'h601)), 2'b01, 2'b00);
    send_flit(0, mk_flit(0, 0, PW'(14'h602)), 2'b01, 2'b00);
    apply_reset();
    idle(1, 2'b11);

`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
    $display("[TB] bad route packets");
    send_flit(1, mk_flit(1, 0, PW'(14'h701)), 2'b11, 2'b11);
    send_flit(1, mk_flit(0, 0, PW'(14'h702)), 2'b01, 2'b11);
    send_flit(1, mk_flit(0, 1, PW'(14'h703)), 2'b01, 2'b11);
    send_flit(0, mk_flit(1, 1, PW'(14'h704)), 2'b00, 2'b11);
    send_flit(0, mk_flit(1, 0, PW'(14'h801)), 2'b10, 2'b11);
    send_flit(0, mk_flit(0, 1, PW'(14'h802)), 2'b10, 2'b11);
    idle(3, 2'b11);
`endif

    $display("[TB] random traffic");
    rem = 0;
    for (int k = 0; k < 500; k++) begin
      int            r;
      int            vc;
      int            len;
      logic [CH-1:0] vld;
      logic [CH-1:0] ordy;
      logic [FW-1:0] fl;
      logic [EN-1:0] rt;
      r    = int'($urandom_range(0, 99));
      len  = 1;
      vld  = '0;
      fl   = '0;
      rt   = EN'(1) << $urandom_range(0, EN - 1);
      ordy = ($urandom_range(0, 3) != 0) ? CH'($urandom) | CH'(1) : '0;
`ifdef NOC_ROUTE_SELECTOR_ERROR_CHECK_EN
      if ($urandom_range(0, 9) == 0) rt = ($urandom_range(0, 1) != 0) ? '1 : '0;
`endif
      if (lock_vc_m >= 0 && r < 60) begin
        vld = CH'(1) << lock_vc_m;
        fl  = mk_flit(1'b0, rem == 1, PW'($urandom));
      end else if (r < 85) begin
        vc  = int'($urandom_range(0, CH - 1));
        if (lock_vc_m >= 0 && vc == lock_vc_m) vc = (lock_vc_m + 1) % CH;
        len = int'($urandom_range(1, 4));
        vld = CH'(1) << vc;
        fl  = mk_flit(1'b1, len == 1, PW'($urandom));
      end
      apply_stimulus(vld, fl, rt, ordy, CH'($urandom));
      if (last_acc) begin
        if (fl[HEAD]) rem = len - 1;
        else rem--;
      end
    end
    idle(4, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
